// File: rtl/system_memory_arbiter.sv
// Round-robin arbiter sharing one external memory port between two cores.
// Grants are burst-locked until i_MEM_Last (or watchdog expiry), followed by one idle gap cycle.
module system_memory_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 21,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,

    input  logic                     i_Core0_MEM_Valid,
    input  logic [ADDRESS_WIDTH-1:0] i_Core0_MEM_Address,
    input  logic                     i_Core0_MEM_Read_Write_n,
    input  logic [DATA_WIDTH-1:0]    i_Core0_MEM_Data,
    output logic                     o_Core0_MEM_Valid,
    output logic                     o_Core0_MEM_Data_Read,
    output logic                     o_Core0_MEM_Last,
    output logic [DATA_WIDTH-1:0]    o_Core0_MEM_Data,

    input  logic                     i_Core1_MEM_Valid,
    input  logic [ADDRESS_WIDTH-1:0] i_Core1_MEM_Address,
    input  logic                     i_Core1_MEM_Read_Write_n,
    input  logic [DATA_WIDTH-1:0]    i_Core1_MEM_Data,
    output logic                     o_Core1_MEM_Valid,
    output logic                     o_Core1_MEM_Data_Read,
    output logic                     o_Core1_MEM_Last,
    output logic [DATA_WIDTH-1:0]    o_Core1_MEM_Data,

    output logic                     o_MEM_Valid,
    output logic [ADDRESS_WIDTH-1:0] o_MEM_Address,
    output logic                     o_MEM_Read_Write_n,
    output logic [DATA_WIDTH-1:0]    o_MEM_Data,
    input  logic                     i_MEM_Data_Read,
    input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
    input  logic                     i_MEM_Valid,
    input  logic                     i_MEM_Last,

    output logic [1:0]               o_Grant,
    output logic                     o_Timeout
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1, GAP} state_t;

    state_t         r_State, w_Next_State;
    logic           r_Last_Granted, w_Next_Last_Granted;
    logic [WDW-1:0] r_Wd_Count, w_Next_Wd_Count;
    logic           r_Timeout, w_Next_Timeout;
    logic           w_Serve0, w_Serve1;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_State        <= IDLE;
            r_Last_Granted <= 1'b1;
            r_Wd_Count     <= '0;
            r_Timeout      <= 1'b0;
        end else begin
            r_State        <= w_Next_State;
            r_Last_Granted <= w_Next_Last_Granted;
            r_Wd_Count     <= w_Next_Wd_Count;
            r_Timeout      <= w_Next_Timeout;
        end
    end

    always_comb begin
        w_Next_State        = r_State;
        w_Next_Last_Granted = r_Last_Granted;
        w_Next_Wd_Count     = r_Wd_Count;
        w_Next_Timeout      = 1'b0;
        case (r_State)
            IDLE: begin
                if (i_Core0_MEM_Valid && i_Core1_MEM_Valid)
                    w_Next_State = r_Last_Granted ? SERVE0 : SERVE1;
                else if (i_Core0_MEM_Valid)
                    w_Next_State = SERVE0;
                else if (i_Core1_MEM_Valid)
                    w_Next_State = SERVE1;
            end
            SERVE0, SERVE1: begin
                // A Last coinciding with watchdog expiry is a normal completion.
                if (i_MEM_Last || (r_Wd_Count == WD_MAX)) begin
                    w_Next_State        = GAP;
                    w_Next_Last_Granted = (r_State == SERVE1);
                    w_Next_Wd_Count     = '0;
                    w_Next_Timeout      = !i_MEM_Last;
                end else begin
                    w_Next_Wd_Count = r_Wd_Count + 1'b1;
                end
            end
            GAP:     w_Next_State = IDLE;
            default: w_Next_State = IDLE;
        endcase
    end

    assign w_Serve0 = (r_State == SERVE0);
    assign w_Serve1 = (r_State == SERVE1);

    // Everything is gated by state so IDLE/GAP/reset drive solid zeros.
    assign o_MEM_Valid        = w_Serve0 | w_Serve1;
    assign o_MEM_Address      = w_Serve0 ? i_Core0_MEM_Address :
                                w_Serve1 ? i_Core1_MEM_Address : '0;
    assign o_MEM_Read_Write_n = (w_Serve0 & i_Core0_MEM_Read_Write_n) |
                                (w_Serve1 & i_Core1_MEM_Read_Write_n);
    assign o_MEM_Data         = w_Serve0 ? i_Core0_MEM_Data :
                                w_Serve1 ? i_Core1_MEM_Data : '0;

    assign o_Core0_MEM_Valid     = w_Serve0 & i_MEM_Valid;
    assign o_Core0_MEM_Data_Read = w_Serve0 & i_MEM_Data_Read;
    assign o_Core0_MEM_Last      = w_Serve0 & i_MEM_Last;
    assign o_Core0_MEM_Data      = w_Serve0 ? i_MEM_Data : '0;

    assign o_Core1_MEM_Valid     = w_Serve1 & i_MEM_Valid;
    assign o_Core1_MEM_Data_Read = w_Serve1 & i_MEM_Data_Read;
    assign o_Core1_MEM_Last      = w_Serve1 & i_MEM_Last;
    assign o_Core1_MEM_Data      = w_Serve1 ? i_MEM_Data : '0;

    assign o_Grant   = {w_Serve1, w_Serve0};
    assign o_Timeout = r_Timeout;

endmodule

// File: tb/tb_system_memory_arbiter.sv
// Bench for system_memory_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of owner/gap/watchdog.
module tb_system_memory_arbiter;

    localparam int DW = 32;
    localparam int AW = 21;
    localparam int TO = 16;

    logic i_Clk = 1'b0;
    logic i_Reset_n = 1'b0;
    always #5 i_Clk = ~i_Clk;

    logic          v0 = 0, rw0 = 0, v1 = 0, rw1 = 0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0, md = '0;
    logic          mv = 0, mdr = 0, mlast = 0;

    logic          o_Core0_MEM_Valid, o_Core0_MEM_Data_Read, o_Core0_MEM_Last;
    logic          o_Core1_MEM_Valid, o_Core1_MEM_Data_Read, o_Core1_MEM_Last;
    logic [DW-1:0] o_Core0_MEM_Data, o_Core1_MEM_Data, o_MEM_Data;
    logic          o_MEM_Valid, o_MEM_Read_Write_n, o_Timeout;
    logic [AW-1:0] o_MEM_Address;
    logic [1:0]    o_Grant;

    system_memory_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .i_Clk(i_Clk), .i_Reset_n(i_Reset_n),
        .i_Core0_MEM_Valid(v0), .i_Core0_MEM_Address(a0),
        .i_Core0_MEM_Read_Write_n(rw0), .i_Core0_MEM_Data(d0),
        .o_Core0_MEM_Valid(o_Core0_MEM_Valid), .o_Core0_MEM_Data_Read(o_Core0_MEM_Data_Read),
        .o_Core0_MEM_Last(o_Core0_MEM_Last), .o_Core0_MEM_Data(o_Core0_MEM_Data),
        .i_Core1_MEM_Valid(v1), .i_Core1_MEM_Address(a1),
        .i_Core1_MEM_Read_Write_n(rw1), .i_Core1_MEM_Data(d1),
        .o_Core1_MEM_Valid(o_Core1_MEM_Valid), .o_Core1_MEM_Data_Read(o_Core1_MEM_Data_Read),
        .o_Core1_MEM_Last(o_Core1_MEM_Last), .o_Core1_MEM_Data(o_Core1_MEM_Data),
        .o_MEM_Valid(o_MEM_Valid), .o_MEM_Address(o_MEM_Address),
        .o_MEM_Read_Write_n(o_MEM_Read_Write_n), .o_MEM_Data(o_MEM_Data),
        .i_MEM_Data_Read(mdr), .i_MEM_Data(md), .i_MEM_Valid(mv), .i_MEM_Last(mlast),
        .o_Grant(o_Grant), .o_Timeout(o_Timeout)
    );

    // Model: which core owns the port (-1 none), whether a gap cycle is due,
    // cycles spent in the current grant, who was served last, timeout pulse.
    int m_own, m_last, m_beats;
    bit m_gap, m_to;
    int n_checks = 0, n_err = 0;

    task automatic m_reset();
        m_own = -1; m_gap = 0; m_last = 1; m_beats = 0; m_to = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem(input logic v, input logic dr, input logic l, input logic [DW-1:0] d);
        mv = v; mdr = dr; mlast = l; md = d;
    endtask

    // One clock: check all outputs at the falling edge, advance model at the rising edge.
    task automatic cyc();
        logic [63:0] e_bus, e_c0, e_c1, e_st;
        @(negedge i_Clk);
        e_bus = '0; e_c0 = '0; e_c1 = '0;
        if (m_own == 0) begin
            e_bus = {9'b0, 1'b1, rw0, a0, d0};
            e_c0  = {29'b0, mv, mdr, mlast, md};
        end else if (m_own == 1) begin
            e_bus = {9'b0, 1'b1, rw1, a1, d1};
            e_c1  = {29'b0, mv, mdr, mlast, md};
        end
        e_st = {61'b0, (m_own == 1), (m_own == 0), m_to};
        chk("mem_bus", {9'b0, o_MEM_Valid, o_MEM_Read_Write_n, o_MEM_Address, o_MEM_Data}, e_bus);
        chk("core0_out", {29'b0, o_Core0_MEM_Valid, o_Core0_MEM_Data_Read, o_Core0_MEM_Last, o_Core0_MEM_Data}, e_c0);
        chk("core1_out", {29'b0, o_Core1_MEM_Valid, o_Core1_MEM_Data_Read, o_Core1_MEM_Last, o_Core1_MEM_Data}, e_c1);
        chk("grant_timeout", {61'b0, o_Grant, o_Timeout}, e_st);
        @(posedge i_Clk);
        if (!i_Reset_n) m_reset();
        else begin
            m_to = 0;
            if (m_own >= 0) begin
                if (mlast || m_beats + 1 == TO) begin
                    m_to = !mlast; m_last = m_own; m_own = -1; m_gap = 1; m_beats = 0;
                end else m_beats++;
            end else if (m_gap) m_gap = 0;
            else if (v0 && v1) m_own = 1 - m_last;
            else if (v0) m_own = 0;
            else if (v1) m_own = 1;
        end
        #1;
    endtask

    task automatic wait_grant(input logic [1:0] g, input string tag);
        int n = 0;
        while (o_Grant !== g && n < 20) begin cyc(); n++; end
        chk(tag, 64'(o_Grant), 64'(g));
    endtask

    // Both cores request; each burst is 3 beats. Records grant order.
    task automatic serve_both(input string tag);
        logic [1:0] order[$];
        logic [1:0] g, prev = 2'b00;
        int beat = 0;
        v0 = 1; v1 = 1; rw0 = 1; rw1 = 1;
        for (int i = 0; i < 40 && (v0 || v1); i++) begin
            g = o_Grant;
            if (g != 2'b00 && g != prev) begin order.push_back(g); beat = 0; end
            prev = g;
            if (g != 2'b00) begin beat++; mem(1, 0, beat == 3, $urandom); end
            else mem(0, 0, 0, '0);
            cyc();
            if (g != 2'b00 && beat == 3) begin
                if (g == 2'b01) v0 = 0; else v1 = 0;
            end
        end
        mem(0, 0, 0, '0);
        chk({tag, "_count"}, 64'(order.size()), 64'd2);
        if (order.size() == 2) begin
            chk({tag, "_first"}, 64'(order[0]), 64'd1);
            chk({tag, "_second"}, 64'(order[1]), 64'd2);
        end
    endtask

    initial begin
        int rd_beats, cv, ct, ob;
        m_reset();
        // Reset held with garbage on the memory strobes.
        for (int i = 0; i < 3; i++) begin
            mem(1, 1, 1, $urandom);
            v0 = 1; v1 = 1;
            cyc();
        end
        v0 = 0; v1 = 0; mem(0, 0, 0, '0);
        i_Reset_n = 1;
        cyc();

        // Core0 read alone, 4 beats.
        v0 = 1; rw0 = 1; a0 = AW'($urandom); d0 = $urandom;
        cyc();
        chk("grant_latency", 64'(o_Grant), 64'd1);
        rd_beats = 0;
        for (int b = 0; b < 4; b++) begin
            mem(1, 0, b == 3, $urandom);
            #1;
            if (o_Core0_MEM_Valid) rd_beats++;
            cyc();
        end
        chk("rd_beats", 64'(rd_beats), 64'd4);
        v0 = 0; v1 = 1; rw1 = 1; mem(0, 0, 0, '0);
        chk("gap_grant", 64'(o_Grant), 64'd0);
        cyc();
        chk("idle_grant", 64'(o_Grant), 64'd0);
        cyc();
        chk("after_gap_grant", 64'(o_Grant), 64'd2);
        mem(1, 0, 1, $urandom);
        cyc();
        v1 = 0; mem(0, 0, 0, '0);

        // Simultaneous requests, twice.
        serve_both("rr1");
        serve_both("rr2");

        // Core1 write burst.
        v1 = 1; rw1 = 0; a1 = 21'h1A2B3; d1 = $urandom;
        wait_grant(2'b10, "wr_grant");
        for (int b = 0; b < 4; b++) begin
            mem(0, b[0], b == 3, $urandom);
            d1 = $urandom;
            #1;
            chk("wr_rw", 64'(o_MEM_Read_Write_n), 64'd0);
            chk("wr_addr", 64'(o_MEM_Address), 64'h1A2B3);
            chk("wr_dr_mirror", 64'(o_Core1_MEM_Data_Read), 64'(mdr));
            chk("wr_core0_quiet", {29'b0, o_Core0_MEM_Valid, o_Core0_MEM_Data_Read, o_Core0_MEM_Last, o_Core0_MEM_Data}, 64'd0);
            cyc();
        end
        v1 = 0; mem(0, 0, 0, '0);

        // Watchdog: core0 never sees Last, core1 pending.
        v0 = 1; rw0 = 1;
        wait_grant(2'b01, "wd_grant0");
        v1 = 1; rw1 = 1;
        cv = 0; ct = 0;
        for (int i = 0; i < 40 && o_Grant !== 2'b10; i++) begin
            if (o_Grant == 2'b01 && o_MEM_Valid) cv++;
            if (o_Timeout) begin ct++; v0 = 0; end
            cyc();
        end
        chk("wd_valid_cycles", 64'(cv), 64'(TO));
        chk("wd_pulses", 64'(ct), 64'd1);
        chk("wd_next_grant", 64'(o_Grant), 64'd2);

        // Async reset in the middle of core1's burst.
        mem(1, 0, 0, $urandom);
        cyc();
        cyc();
        i_Reset_n = 0;
        #1;
        chk("rst_async_valid", 64'(o_MEM_Valid), 64'd0);
        chk("rst_async_grant", 64'(o_Grant), 64'd0);
        m_reset();
        mem(0, 0, 0, '0);
        cyc();
        i_Reset_n = 1; v0 = 1; v1 = 1;
        cyc();
        chk("rst_first_grant", 64'(o_Grant), 64'd1);
        mem(1, 0, 1, $urandom);
        cyc();
        v0 = 0; mem(0, 0, 0, '0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!v0 && $urandom_range(2) == 0) begin v0 = 1; a0 = AW'($urandom); rw0 = 1'($urandom_range(1)); end
            if (!v1 && $urandom_range(2) == 0) begin v1 = 1; a1 = AW'($urandom); rw1 = 1'($urandom_range(1)); end
            if (v0 && $urandom_range(19) == 0) v0 = 0;
            if (v1 && $urandom_range(19) == 0) v1 = 0;
            d0 = $urandom; d1 = $urandom;
            mem(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(7) == 0, $urandom);
            ob = m_own;
            cyc();
            if (ob == 0 && m_own < 0) v0 = 0;
            if (ob == 1 && m_own < 0) v1 = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/system_memory_arbiter.md
Name: system_memory_arbiter

Overview:
- Shares one external memory port between two cores; each core's memory-side interface (valid/address/rw/data, responses) connects unmodified.
- Sits between the per-core instruction/data arbiters and the off-chip memory controller.
- Grants are registered and round-robin. A grant is locked for a whole burst until i_MEM_Last.
- One idle turnaround cycle follows every burst.
- A watchdog forcibly ends a grant that never sees i_MEM_Last.

Parameters:
DATA_WIDTH, 32, data bus width
ADDRESS_WIDTH, 21, word address width
TIMEOUT_CYCLES, 1024, max cycles in a grant without i_MEM_Last before forced release (>=2)

Ports:
i_Clk  in  1  clock
i_Reset_n  in  1  asynchronous active-low reset
i_Core0_MEM_Valid  in  1  core0 request valid, held for the whole transaction
i_Core0_MEM_Address  in  ADDRESS_WIDTH  core0 word address
i_Core0_MEM_Read_Write_n  in  1  1=read, 0=write
i_Core0_MEM_Data  in  DATA_WIDTH  core0 write data
o_Core0_MEM_Valid  out  1  read beat valid to core0
o_Core0_MEM_Data_Read  out  1  write beat consumed, to core0
o_Core0_MEM_Last  out  1  last beat to core0
o_Core0_MEM_Data  out  DATA_WIDTH  read data to core0
i_Core1_* / o_Core1_*  (same eight ports, same widths/meanings, for core1)
o_MEM_Valid  out  1  request to memory
o_MEM_Address  out  ADDRESS_WIDTH  address to memory
o_MEM_Read_Write_n  out  1  direction to memory
o_MEM_Data  out  DATA_WIDTH  write data to memory
i_MEM_Data_Read  in  1  memory consumed write beat
i_MEM_Data  in  DATA_WIDTH  read data from memory
i_MEM_Valid  in  1  read beat valid
i_MEM_Last  in  1  final beat of transaction
o_Grant  out  2  one-hot current grant, bit0=core0; 00 when none
o_Timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- States: IDLE, SERVE0, SERVE1, GAP. Register Last_Granted (1 bit) and beat counter Wd_Count ($clog2(TIMEOUT_CYCLES+1) bits).
- Reset (async): state IDLE, Last_Granted=1 so core0 wins the first tie, Wd_Count=0.
- All outputs are 0 while in reset or IDLE/GAP, including data and address; no X driving.
- IDLE:
  - Only core0 valid -> SERVE0. Only core1 valid -> SERVE1.
  - Both valid -> grant the core != Last_Granted.
  - Neither valid -> stay in IDLE.
  - o_MEM_Valid=0 in IDLE. Grant latency is one cycle: a request sampled in IDLE at cycle N gives o_MEM_Valid=1 at N+1.
- SERVEx:
  - o_MEM_Valid=1 unconditionally. o_MEM_Address/Read_Write_n/Data = core x inputs, combinational pass-through.
  - o_Corex_Valid/Data_Read/Last/Data = i_MEM_Valid/i_MEM_Data_Read/i_MEM_Last/i_MEM_Data. The non-granted core's outputs stay 0.
  - o_Grant = one-hot x.
  - i_MEM_Last=1 -> GAP, Last_Granted<=x, Wd_Count<=0.
  - Otherwise Wd_Count increments. When Wd_Count == TIMEOUT_CYCLES-1 with no i_MEM_Last: -> GAP, Last_Granted<=x, o_Timeout=1 for the following cycle (registered), Wd_Count<=0.
- GAP: exactly one cycle, all memory outputs 0, then -> IDLE. The minimum spacing between the last beat of one burst and o_MEM_Valid of the next is 2 idle cycles.
- Requests arriving during SERVE/GAP wait; they are never lost while their valid is held.
- Core valid deasserted mid-SERVE does not end the grant; only i_MEM_Last or the watchdog ends it.
- i_MEM_* strobes in IDLE/GAP are ignored and not routed to either core.
- Simultaneous i_MEM_Last and watchdog expiry: treated as normal completion, no o_Timeout.
- Reset mid-burst: grant drops immediately and asynchronously. The memory controller is reset by the same signal.

Test Plan:
- Core0 read alone, memory returns 4 beats, Last on beat 4 -> o_Grant=01 one cycle after the request; core0 gets 4 valid beats; o_Grant=00 for 2 cycles before IDLE accepts again.
- Both request in the same cycle after reset -> core0 served first, then core1. Both request again -> core0 then core1 again (Last_Granted=1 after core1 finishes).
- Core1 write, 4 beats, address 0x1A2B3 -> o_MEM_Read_Write_n=0, o_MEM_Address=0x1A2B3; o_Core1_MEM_Data_Read mirrors i_MEM_Data_Read; core0 outputs stay 0 throughout.
- Core0 granted, memory never asserts Last, TIMEOUT_CYCLES=16 -> o_MEM_Valid high 16 cycles, then o_Timeout pulses once, state enters GAP, pending core1 is granted next.
- i_Reset_n low for 1 cycle mid-burst of core1 -> o_MEM_Valid and o_Grant go 0 asynchronously. After release, both request -> core0 granted first.
